id_ex_skid: RTL

ID_EX_SKID -- requirements
Module: id_ex_skid

---
 rtl/decode_pkg.sv | 14 +
 rtl/skid_mem2.sv | 33 +++
 rtl/id_ex_skid.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared defaults and types for the ID/EX skid buffer slice.
package decode_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_CTRL_W = 40;
    localparam int DEF_CNT_W  = 16;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/skid_mem2.sv
// Two-entry register array holding {ctrl, data}; written on push, read by pointer.
module skid_mem2 #(
    parameter int W = 168
) (
    input  logic         clk,
    input  logic         we,
    input  logic         wr_ptr,
    input  logic [W-1:0] wdata,
    input  logic         rd_ptr,
    output logic [W-1:0] rdata
);

    logic [1:0][W-1:0] mem_q;
    logic [1:0][W-1:0] mem_d;

    // Next storage contents: only the addressed slot changes, and only on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wr_ptr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Payload storage carries no reset; validity is tracked by the owner's count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr];

endmodule

// File: rtl/id_ex_skid.sv
// ID->EX 2-entry skid buffer with flush/hold/hazard control.
// Optional perf counters enabled by defining ID_EX_SKID_PERF_EN.
module id_ex_skid
    import decode_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hazard,
    input  logic              flush,
    input  logic              hold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output occ_t              occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int ENT_W = CTRL_W + DATA_W;

    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    occ_t              count_q,  count_d;
    logic              push_s;
    logic              pop_s;
    logic [ENT_W-1:0]  rd_entry_s;

    skid_mem2 #(
        .W (ENT_W)
    ) u_mem (
        .clk    (clk),
        .we     (push_s),
        .wr_ptr (wr_ptr_q),
        .wdata  ({in_ctrl, in_data}),
        .rd_ptr (rd_ptr_q),
        .rdata  (rd_entry_s)
    );

    // Handshake and head presentation; in_ready depends only on state and the ID-side controls.
    always_comb begin
        in_ready  = Rst_n && !hold && !hazard && !flush && (count_q < OCC_FULL);
        out_valid = (count_q != OCC_EMPTY);
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready && !hold;
        occupancy = count_q;
        if (out_valid) begin
            out_ctrl = rd_entry_s[ENT_W-1 -: CTRL_W];
            out_data = rd_entry_s[DATA_W-1:0];
        end else begin
            out_ctrl = {CTRL_W{1'b0}};
            out_data = {DATA_W{1'b0}};
        end
    end

    // Pointer/count next state: flush beats hold, hold beats push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = OCC_EMPTY;
        end else if (hold) begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
        end else begin
            wr_ptr_d = push_s ? ~wr_ptr_q : wr_ptr_q;
            rd_ptr_d = pop_s  ? ~rd_ptr_q : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + OCC_ONE;
                2'b01:   count_d = count_q - OCC_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= OCC_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef ID_EX_SKID_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating perf counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (out_ready && !out_valid && !hold && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Counter state, cleared only by reset.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q  <= {CNT_W{1'b0}};
            bubble_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = {CNT_W{1'b0}};
    assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule
